// File: rtl/dcp_xbar_pkg.sv
// Shared definitions for the M-by-N decoupled crossbar: arbitration mode
// codes, the per-output arbiter state type and the FIFO entry layout helper.
package dcp_xbar_pkg;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // A FIFO entry is packed as {pld, dst, last}; this returns its width.
  function automatic int entry_w(input int dw, input int aw);
    return dw + aw + 1;
  endfunction

endpackage

// File: rtl/dcp_xbar_arb.sv
// M-way arbiter for one crossbar output. Grants round-robin or lowest-index
// among requesters while idle, locks onto one input for the rest of a
// multi-beat packet, and keeps a stalled grant until the beat is taken.
module dcp_xbar_arb
  import dcp_xbar_pkg::*;
#(
  parameter int M        = 4,
  parameter int ARB_MODE = ARB_RR,
  parameter int IW       = (M > 1) ? $clog2(M) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [M-1:0]  req,
  input  logic [M-1:0]  last,
  input  logic          rdy,
  output logic          gnt_vld,
  output logic [IW-1:0] gnt_idx
);

  arb_state_e    state_reg, state_next;
  logic [IW-1:0] lock_reg, lock_next;
  logic [IW-1:0] ptr_reg, ptr_next;
  logic          stall_reg, stall_next;
  logic [IW-1:0] held_reg, held_next;
  logic          pick_vld;
  logic [IW-1:0] pick_idx;
  int            scan;

  // Fresh arbitration pick; scanning downward lets the lowest offset win.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    scan     = 0;
    for (int k = M - 1; k >= 0; k--) begin
      if (ARB_MODE == ARB_FIXED) scan = k;
      else                       scan = (int'(ptr_reg) + k) % M;
      if (req[scan]) begin
        pick_vld = 1'b1;
        pick_idx = IW'(scan);
      end
    end
  end

  // Grant selection and next-state: lock wins, then a stalled grant, then a fresh pick.
  always_comb begin
    state_next = state_reg;
    lock_next  = lock_reg;
    ptr_next   = ptr_reg;
    gnt_vld    = 1'b0;
    gnt_idx    = '0;
    if (state_reg == ARB_LOCKED) begin
      gnt_idx = lock_reg;
      gnt_vld = req[lock_reg];
    end else if (stall_reg) begin
      gnt_idx = held_reg;
      gnt_vld = req[held_reg];
    end else begin
      gnt_idx = pick_idx;
      gnt_vld = pick_vld;
    end
    stall_next = gnt_vld && !rdy;
    held_next  = gnt_idx;
    if (gnt_vld && rdy) begin
      if (last[gnt_idx]) begin
        state_next = ARB_IDLE;
        ptr_next   = IW'((int'(gnt_idx) + 1) % M);
      end else if (state_reg == ARB_IDLE) begin
        state_next = ARB_LOCKED;
        lock_next  = gnt_idx;
      end
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ARB_IDLE;
      lock_reg  <= '0;
      ptr_reg   <= '0;
      stall_reg <= 1'b0;
      held_reg  <= '0;
    end else begin
      state_reg <= state_next;
      lock_reg  <= lock_next;
      ptr_reg   <= ptr_next;
      stall_reg <= stall_next;
      held_reg  <= held_next;
    end
  end

endmodule

// File: rtl/dcp_xbar_mxn.sv
// M-input by N-output decoupled crossbar. Each input has a small elastic
// FIFO whose head is routed combinationally to the output named by its dst
// field; heads addressed past the last output are dropped and counted.
module dcp_xbar_mxn
  import dcp_xbar_pkg::*;
#(
  parameter int DW       = 16,
  parameter int AW       = 4,
  parameter int M        = 4,
  parameter int N        = 4,
  parameter int DEPTH    = 2,
  parameter int ARB_MODE = ARB_RR,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [M-1:0]       up_vld,
  output logic [M-1:0]       up_rdy,
  input  logic [M*DW-1:0]    up_pld,
  input  logic [M*AW-1:0]    up_dst,
  input  logic [M-1:0]       up_last,
  output logic [N-1:0]       dn_vld,
  input  logic [N-1:0]       dn_rdy,
  output logic [N*DW-1:0]    dn_pld,
  output logic [N*AW-1:0]    dn_dst,
  output logic [N-1:0]       dn_last,
  output logic [M*CNT_W-1:0] drop_cnt
);

  localparam int IW = (M > 1) ? $clog2(M) : 1;
  localparam int PW = $clog2(DEPTH);
  localparam int EW = entry_w(DW, AW);

  if ($clog2(N) > AW) begin : g_bad_aw
    $fatal(1, "dcp_xbar_mxn: AW is too narrow to address N outputs");
  end

  logic          run_reg;
  logic [DW-1:0] head_pld [M];
  logic [AW-1:0] head_dst [M];
  logic [M-1:0]  head_last;
  logic [M-1:0]  head_vld;
  logic [M-1:0]  drop;
  logic [N-1:0]  gnt_vld;
  logic [IW-1:0] gnt_idx [N];

  // Holds every input not-ready until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_reg <= 1'b0;
    else        run_reg <= 1'b1;
  end

  for (genvar gi = 0; gi < M; gi++) begin : g_in
    logic [EW-1:0]    mem [DEPTH];
    logic [EW-1:0]    head_ent;
    logic [PW-1:0]    wr_reg, rd_reg;
    logic [PW:0]      cnt_reg;
    logic [CNT_W-1:0] dcnt_reg;
    logic             push, pop;

    assign up_rdy[gi]    = run_reg && (cnt_reg != (PW+1)'(DEPTH));
    assign push          = up_vld[gi] && up_rdy[gi];
    assign head_ent      = mem[rd_reg];
    assign head_pld[gi]  = head_ent[EW-1 -: DW];
    assign head_dst[gi]  = head_ent[AW:1];
    assign head_last[gi] = head_ent[0];
    assign head_vld[gi]  = (cnt_reg != '0);
    assign drop[gi]      = head_vld[gi] && (32'(head_dst[gi]) >= 32'(N));
    assign drop_cnt[gi*CNT_W +: CNT_W] = dcnt_reg;

    // Head leaves on a drop or when the output holding its grant takes it.
    always_comb begin
      pop = drop[gi];
      for (int j = 0; j < N; j++) begin
        if (gnt_vld[j] && dn_rdy[j] && (gnt_idx[j] == IW'(gi))) pop = 1'b1;
      end
    end

    // FIFO storage; contents need no reset since occupancy is tracked separately.
    always_ff @(posedge clk) begin
      if (push) mem[wr_reg] <= {up_pld[gi*DW +: DW], up_dst[gi*AW +: AW], up_last[gi]};
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_reg  <= '0;
        rd_reg  <= '0;
        cnt_reg <= '0;
      end else begin
        if (push) wr_reg <= wr_reg + 1'b1;
        if (pop)  rd_reg <= rd_reg + 1'b1;
        cnt_reg <= cnt_reg + (PW+1)'(push) - (PW+1)'(pop);
      end
    end

    // Saturating count of beats dropped for an out-of-range destination.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                         dcnt_reg <= '0;
      else if (drop[gi] && dcnt_reg != '1) dcnt_reg <= dcnt_reg + 1'b1;
    end
  end

  for (genvar gj = 0; gj < N; gj++) begin : g_out
    logic [M-1:0] req_j;

    // An input requests this output when its head is addressed to it.
    always_comb begin
      req_j = '0;
      for (int i = 0; i < M; i++) begin
        req_j[i] = head_vld[i] && (32'(head_dst[i]) == 32'(gj));
      end
    end

    dcp_xbar_arb #(
      .M        (M),
      .ARB_MODE (ARB_MODE),
      .IW       (IW)
    ) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req_j),
      .last    (head_last),
      .rdy     (dn_rdy[gj]),
      .gnt_vld (gnt_vld[gj]),
      .gnt_idx (gnt_idx[gj])
    );

    assign dn_vld[gj]            = gnt_vld[gj];
    assign dn_pld[gj*DW +: DW]   = head_pld[gnt_idx[gj]];
    assign dn_dst[gj*AW +: AW]   = head_dst[gnt_idx[gj]];
    assign dn_last[gj]           = gnt_vld[gj] && head_last[gnt_idx[gj]];
  end

endmodule

// File: tb/tb_dcp_xbar_mxn.sv
// Bench for dcp_xbar_mxn at M=N=4, DEPTH=2: a vector table of single
// transfers, hand sequences for arbitration, locking, backpressure, drop
// saturation and mid-packet reset, then random traffic against a queue model.
module tb_dcp_xbar_mxn;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  up_vld, up_rdy, up_last;
  logic [63:0] up_pld;
  logic [15:0] up_dst;
  logic [3:0]  dn_vld, dn_rdy, dn_last;
  logic [63:0] dn_pld;
  logic [15:0] dn_dst;
  logic [31:0] drop_cnt;
  logic [3:0]  fx_up_rdy, fx_dn_vld, fx_dn_last;
  logic [63:0] fx_dn_pld;
  logic [15:0] fx_dn_dst;
  logic [31:0] fx_drop_cnt;

  always #5 clk = ~clk;

  dcp_xbar_mxn #(.DW(16), .AW(4), .M(4), .N(4), .DEPTH(2), .ARB_MODE(0), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .up_vld(up_vld), .up_rdy(up_rdy), .up_pld(up_pld),
    .up_dst(up_dst), .up_last(up_last), .dn_vld(dn_vld), .dn_rdy(dn_rdy),
    .dn_pld(dn_pld), .dn_dst(dn_dst), .dn_last(dn_last), .drop_cnt(drop_cnt));

  dcp_xbar_mxn #(.DW(16), .AW(4), .M(4), .N(4), .DEPTH(2), .ARB_MODE(1), .CNT_W(8)) dut_fx (
    .clk(clk), .rst_n(rst_n), .up_vld(up_vld), .up_rdy(fx_up_rdy), .up_pld(up_pld),
    .up_dst(up_dst), .up_last(up_last), .dn_vld(fx_dn_vld), .dn_rdy(dn_rdy),
    .dn_pld(fx_dn_pld), .dn_dst(fx_dn_dst), .dn_last(fx_dn_last), .drop_cnt(fx_drop_cnt));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    int         src;
    logic [15:0] pld;
    logic [3:0]  dst;
    logic        last;
    logic [3:0]  exp_vld;
    logic [3:0]  exp_last;
  } vec_t;

  typedef struct {
    logic [15:0] pld;
    int          dst;
    bit          last;
  } beat_t;

  // Reference model: per-input FIFO contents and per-output lock/pointer/held grant.
  beat_t mq [4][$];
  int    m_lock [4];
  int    m_ptr  [4];
  int    m_held [4];
  int    m_dcnt [4];
  int    s_rem  [4];
  int    s_dst  [4];
  logic [15:0] got [$];

  function automatic bit heads_to(input int i, input int j);
    return (mq[i].size() > 0) && (mq[i][0].dst == j);
  endfunction

  function automatic int m_grant(input int j);
    int c;
    if (m_lock[j] >= 0)      c = m_lock[j];
    else if (m_held[j] >= 0) c = m_held[j];
    else begin
      for (int k = 0; k < 4; k++) begin
        if (heads_to((m_ptr[j] + k) % 4, j)) return (m_ptr[j] + k) % 4;
      end
      return -1;
    end
    return heads_to(c, j) ? c : -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mq[i].delete();
      m_lock[i] = -1;
      m_ptr[i]  = 0;
      m_held[i] = -1;
      m_dcnt[i] = 0;
      s_rem[i]  = 0;
      s_dst[i]  = 0;
    end
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    up_vld  = '0;
    up_last = '0;
    up_pld  = '0;
    up_dst  = '0;
    dn_rdy  = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Presents one beat on input i and holds it until it is accepted.
  task automatic send_beat(input int i, input logic [15:0] p, input logic [3:0] d, input logic l);
    bit ok;
    ok = 1'b0;
    up_vld[i]          = 1'b1;
    up_pld[i*16 +: 16] = p;
    up_dst[i*4 +: 4]   = d;
    up_last[i]         = l;
    for (int w = 0; w < 40 && !ok; w++) begin
      @(negedge clk);
      ok = up_rdy[i];
      @(posedge clk);
    end
    #1;
    up_vld[i] = 1'b0;
    chk($sformatf("send accepted in%0d", i), 32'(ok), 32'd1);
  endtask

  task automatic collect(input int j, input int n);
    repeat (n) begin
      @(negedge clk);
      if (dn_vld[j] && dn_rdy[j]) begin
        got.push_back(dn_pld[j*16 +: 16]);
        $display("out%0d beat %h last=%0d", j, dn_pld[j*16 +: 16], dn_last[j]);
      end
    end
  endtask

  task automatic chk_got(input string nm, input logic [15:0] e0, input logic [15:0] e1,
                         input logic [15:0] e2, input logic [15:0] e3, input logic [15:0] e4, input int n);
    logic [15:0] e [5];
    e = '{e0, e1, e2, e3, e4};
    chk({nm, " count"}, 32'(got.size()), 32'(n));
    for (int k = 0; k < n && k < got.size(); k++) chk($sformatf("%s beat%0d", nm, k), 32'(got[k]), 32'(e[k]));
  endtask

  vec_t  vecs [6];
  int    gsave [4];
  bit    dropf [4];
  bit    erdy  [4];
  bit    acc_r [4];
  int    acc_n, vld_n, w;
  beat_t b;

  initial begin
    vecs[0] = '{2, 16'hA5A5, 4'd3, 1'b1, 4'b1000, 4'b1000};
    vecs[1] = '{0, 16'h1234, 4'd0, 1'b1, 4'b0001, 4'b0001};
    vecs[2] = '{1, 16'hBEEF, 4'd2, 1'b0, 4'b0100, 4'b0000};
    vecs[3] = '{1, 16'hCAFE, 4'd2, 1'b1, 4'b0100, 4'b0100};
    vecs[4] = '{3, 16'h0F0F, 4'd1, 1'b1, 4'b0010, 4'b0010};
    vecs[5] = '{0, 16'h5555, 4'd9, 1'b1, 4'b0000, 4'b0000};

    // Reset state
    rst_n = 1'b0; up_vld = '0; up_last = '0; up_pld = '0; up_dst = '0; dn_rdy = '1;
    @(negedge clk);
    chk("reset up_rdy", 32'(up_rdy), 32'h0);
    chk("reset dn_vld", 32'(dn_vld), 32'h0);
    chk("reset dn_last", 32'(dn_last), 32'h0);
    chk("reset drop_cnt", drop_cnt, 32'h0);
    do_reset();
    chk("up_rdy after release", 32'(up_rdy), 32'hF);

    // Table of single transfers
    for (int v = 0; v < 6; v++) begin
      up_vld[vecs[v].src]           = 1'b1;
      up_pld[vecs[v].src*16 +: 16]  = vecs[v].pld;
      up_dst[vecs[v].src*4 +: 4]    = vecs[v].dst;
      up_last[vecs[v].src]          = vecs[v].last;
      @(posedge clk); #1;
      up_vld = '0;
      @(negedge clk);
      $display("vec %0d: in%0d pld=%h dst=%0d last=%0d -> dn_vld=%b", v, vecs[v].src,
               vecs[v].pld, vecs[v].dst, vecs[v].last, dn_vld);
      chk($sformatf("vec%0d dn_vld", v), 32'(dn_vld), 32'(vecs[v].exp_vld));
      chk($sformatf("vec%0d dn_last", v), 32'(dn_last), 32'(vecs[v].exp_last));
      if (vecs[v].exp_vld != 4'b0000)
        chk($sformatf("vec%0d dn_pld", v), 32'(dn_pld[int'(vecs[v].dst)*16 +: 16]), 32'(vecs[v].pld));
      @(posedge clk); #1;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("vec drop_cnt", drop_cnt, 32'h0000_0001);

    // Round-robin and fixed-priority fairness
    do_reset();
    for (int i = 0; i < 4; i++) begin
      up_pld[i*16 +: 16] = 16'(i);
      up_dst[i*4 +: 4]   = 4'd1;
    end
    up_last = '1;
    up_vld  = '1;
    w = 0;
    @(negedge clk);
    while (!dn_vld[1] && w < 20) begin @(negedge clk); w++; end
    chk("rr first vld", 32'(dn_vld[1]), 32'd1);
    for (int k = 0; k < 5; k++) begin
      $display("fair cycle %0d: rr in%0d fx in%0d", k, dn_pld[31:16], fx_dn_pld[31:16]);
      chk($sformatf("rr grant c%0d", k), 32'(dn_pld[31:16]), 32'(k % 4));
      chk($sformatf("fx vld c%0d", k), 32'(fx_dn_vld[1]), 32'd1);
      chk($sformatf("fx grant c%0d", k), 32'(fx_dn_pld[31:16]), 32'd0);
      @(negedge clk);
    end
    up_vld = '0;

    // Packet lock: input 1 holds output 0 for three beats before input 0
    do_reset();
    got.delete();
    fork
      begin
        send_beat(1, 16'h1001, 4'd0, 1'b0);
        send_beat(1, 16'h1002, 4'd0, 1'b0);
        send_beat(1, 16'h1003, 4'd0, 1'b1);
      end
      begin
        @(posedge clk); #1;
        send_beat(0, 16'h0AAA, 4'd0, 1'b1);
      end
      collect(0, 12);
    join
    chk_got("lock", 16'h1001, 16'h1002, 16'h1003, 16'h0AAA, 16'h0000, 4);

    // Backpressure on output 2
    do_reset();
    got.delete();
    dn_rdy[2] = 1'b0;
    fork
      for (int k = 0; k < 5; k++) send_beat(0, 16'(16'h2000 + k), 4'd2, 1'b1);
      begin
        repeat (4) @(posedge clk);
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk($sformatf("bp vld c%0d", k), 32'(dn_vld[2]), 32'd1);
          chk($sformatf("bp pld c%0d", k), 32'(dn_pld[47:32]), 32'h2000);
          chk($sformatf("bp up_rdy c%0d", k), 32'(up_rdy[0]), 32'd0);
        end
        @(posedge clk); #1;
        dn_rdy[2] = 1'b1;
      end
      collect(2, 25);
    join
    chk_got("bp", 16'h2000, 16'h2001, 16'h2002, 16'h2003, 16'h2004, 5);

    // Drop saturation: 300 beats to dst 7
    do_reset();
    up_dst[15:12] = 4'd7; up_last[3] = 1'b1; up_pld[63:48] = 16'h7777; up_vld[3] = 1'b1;
    acc_n = 0; vld_n = 0;
    for (int c = 0; c < 400 && acc_n < 300; c++) begin
      @(negedge clk);
      if (up_rdy[3]) acc_n++;
      if (dn_vld != 4'b0000) vld_n++;
      @(posedge clk);
    end
    #1; up_vld[3] = 1'b0;
    repeat (3) @(negedge clk);
    $display("drop: accepted %0d, drop_cnt=%h", acc_n, drop_cnt);
    chk("drop accepted", 32'(acc_n), 32'd300);
    chk("drop no vld", 32'(vld_n), 32'd0);
    chk("drop saturated", drop_cnt, 32'hFF00_0000);

    // Mid-packet reset while output 1 is locked to input 2
    do_reset();
    send_beat(2, 16'h3001, 4'd1, 1'b0);
    @(posedge clk); #1;
    dn_rdy[1] = 1'b0;
    send_beat(2, 16'h3002, 4'd1, 1'b0);
    @(negedge clk);
    chk("mid locked vld", 32'(dn_vld), 32'b0010);
    chk("mid locked pld", 32'(dn_pld[31:16]), 32'h3002);
    rst_n = 1'b0;
    #1;
    chk("mid reset dn_vld", 32'(dn_vld), 32'h0);
    chk("mid reset up_rdy", 32'(up_rdy), 32'h0);
    chk("mid reset dn_last", 32'(dn_last), 32'h0);
    @(posedge clk);
    up_vld = '0; dn_rdy = '1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_beat(0, 16'h0E0E, 4'd1, 1'b1);
    @(negedge clk);
    $display("after mid reset: dn_vld=%b pld=%h", dn_vld, dn_pld[31:16]);
    chk("post reset vld", 32'(dn_vld), 32'b0010);
    chk("post reset pld", 32'(dn_pld[31:16]), 32'h0E0E);
    chk("post reset last", 32'(dn_last[1]), 32'd1);

    // Random traffic against the queue model
    do_reset();
    model_reset();
    for (int i = 0; i < 4; i++) acc_r[i] = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (!up_vld[i] || acc_r[i]) begin
          if ($urandom_range(9) < 7) begin
            if (s_rem[i] == 0) begin
              s_dst[i] = $urandom_range(5);
              s_rem[i] = $urandom_range(3, 1);
            end
            up_vld[i]          = 1'b1;
            up_pld[i*16 +: 16] = 16'($urandom);
            up_dst[i*4 +: 4]   = 4'(s_dst[i]);
            up_last[i]         = (s_rem[i] == 1);
            s_rem[i]--;
          end else begin
            up_vld[i] = 1'b0;
          end
        end
      end
      for (int j = 0; j < 4; j++) dn_rdy[j] = ($urandom_range(3) != 0);
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        erdy[i]  = (mq[i].size() < 2);
        dropf[i] = (mq[i].size() > 0) && (mq[i][0].dst >= 4);
        chk($sformatf("rnd up_rdy c%0d i%0d", cyc, i), 32'(up_rdy[i]), 32'(erdy[i]));
        chk($sformatf("rnd drop_cnt c%0d i%0d", cyc, i), 32'(drop_cnt[i*8 +: 8]), 32'(m_dcnt[i]));
      end
      for (int j = 0; j < 4; j++) begin
        gsave[j] = m_grant(j);
        chk($sformatf("rnd dn_vld c%0d o%0d", cyc, j), 32'(dn_vld[j]), 32'(gsave[j] >= 0));
        if (gsave[j] >= 0) begin
          chk($sformatf("rnd dn_pld c%0d o%0d", cyc, j), 32'(dn_pld[j*16 +: 16]), 32'(mq[gsave[j]][0].pld));
          chk($sformatf("rnd dn_last c%0d o%0d", cyc, j), 32'(dn_last[j]), 32'(mq[gsave[j]][0].last));
          chk($sformatf("rnd dn_dst c%0d o%0d", cyc, j), 32'(dn_dst[j*4 +: 4]), 32'(j));
        end
      end
      @(posedge clk);
      for (int j = 0; j < 4; j++) begin
        if (gsave[j] >= 0 && dn_rdy[j]) begin
          b = mq[gsave[j]].pop_front();
          if (b.last) begin
            m_lock[j] = -1;
            m_ptr[j]  = (gsave[j] + 1) % 4;
          end else begin
            m_lock[j] = gsave[j];
          end
          m_held[j] = -1;
        end else begin
          m_held[j] = gsave[j];
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (dropf[i]) begin
          b = mq[i].pop_front();
          if (m_dcnt[i] < 255) m_dcnt[i]++;
        end
        acc_r[i] = up_vld[i] && erdy[i];
        if (acc_r[i]) mq[i].push_back('{up_pld[i*16 +: 16], int'(up_dst[i*4 +: 4]), up_last[i]});
      end
      #1;
    end
    up_vld = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dcp_xbar_mxn.md
# dcp_xbar_mxn

Parametrised M-input by N-output Decoupled crossbar for the switch datapath. It is the successor to the fixed NxN route/switch crossbar. It adds a per-input elastic FIFO, a selectable arbitration mode, packet-level grant locking via a last-beat sideband, and counted dropping of beats whose Dst is out of range. It sits between the ingress port logic and the egress queues.

## Interface
- DW, 16: payload width (Pld).
- AW, 4: destination field width (Dst); elaboration fails with $fatal if $clog2(N) > AW.
- M, 4: number of input channels, 1..16.
- N, 4: number of output channels, 1..16.
- DEPTH, 2: per-input FIFO depth, a power of two, at least 2.
- ARB_MODE, 0: 0 = round-robin, 1 = fixed priority with lowest input index winning.
- CNT_W, 8: width of each drop counter.
- iClk, in, 1: the single clock.
- iRst_n, in, 1: reset, asynchronous, active-low.
- iDcpIn[0:M-1], Decoupled.slave, Vld/Rdy/Pld[DW]/Dst[AW]: input channels.
- iLast, in, M: per-input last-beat flag, qualified by iDcpIn[i].Vld.
- oDcpOut[0:N-1], Decoupled.master, Vld/Rdy/Pld[DW]/Dst[AW]: output channels; Dst is passed through unchanged.
- oLast, out, N: per-output last flag, qualified by oDcpOut[j].Vld.
- oDropCnt, out, M*CNT_W: drop counter for input i, at bits [i*CNT_W +: CNT_W].

## Operation
- **Input side.** Each input writes {Pld, Dst, Last} into its own DEPTH-entry FIFO on Vld&&Rdy.
  - iDcpIn[i].Rdy = !full.
  - Rdy is a function of registered state only; it never depends on iDcpIn[i].Vld.
- **Routing.** An input's head entry requests output Dst when Dst < N.
- **Dropping.** A head entry with Dst >= N is popped in one cycle without driving any output.
  - The entry's oDropCnt field increments and saturates at all-ones.
  - A packet is dropped beat by beat; each beat is routed on its own Dst.
- **Per-output arbiter.** One arbiter per output, each with an IDLE/LOCKED state machine.
  - IDLE: grant is computed combinationally among requesters.
    - Round-robin searches upward from ptr_j, wrapping.
    - Fixed priority takes the lowest requesting index.
  - IDLE -> LOCKED on an accepted beat with Last=0. The locked input index is registered.
  - LOCKED: only the locked input may transfer, even if others request. The output idles if the locked input's FIFO is empty.
  - LOCKED -> IDLE on an accepted beat with Last=1.
- **Round-robin pointer.** ptr_j becomes (granted index + 1) mod M, only on an accepted beat with Last=1. A single-beat packet (Last=1 while IDLE) stays IDLE and updates the pointer.
- **Output side.**
  - oDcpOut[j].Vld is asserted when a grant exists.
  - Pld, Dst and oLast come from the granted head.
  - The FIFO pops on oDcpOut[j].Vld && Rdy.
  - Vld, once asserted, holds with stable data until Rdy. Grant is not re-evaluated while Vld && !Rdy.
- **Head-of-line blocking.** Each input head sits in exactly one output's request set, so no input is granted by two outputs.
- **Simultaneous events.**
  - A push and a pop on the same FIFO in the same cycle are both performed; count is unchanged.
  - A push into a full FIFO cannot occur, because Rdy=0.
  - A pop from a full FIFO raises Rdy the next cycle.
- **Reset.**
  - While iRst_n=0: all iDcpIn.Rdy=0, all oDcpOut.Vld=0, oLast=0, oDropCnt=0, FIFOs empty, arbiters IDLE, ptr=0.
  - A reset asserted mid-packet discards all state, including FIFO contents and locks.
  - iDcpIn.Rdy=1 in the first cycle after reset release.

## Timing
- Minimum latency is 1 cycle: a beat accepted at edge t can appear on oDcpOut.Vld in the cycle after edge t. FIFO storage is registered; head-to-output is a combinational mux.
- Per-output throughput is 1 beat/cycle at steady state.
- Per-input throughput is 1 beat/cycle when the output is uncontended. DEPTH=2 sustains full rate with registered Rdy.
- A dropped beat occupies the FIFO head for exactly 1 cycle.
- oDropCnt updates one cycle after the drop edge.

## Structure
- Package dcp_xbar_pkg holds:
  - ARB_RR=0 and ARB_FIXED=1.
  - The arbiter state enum {ARB_IDLE, ARB_LOCKED}.
  - A FIFO entry struct helper that is parameter-free apart from the widths passed at use.
- Sub-module dcp_xbar_arb: an M-way arbiter with lock state and RR pointer, instantiated N times.
- FIFOs, the request decode and the output muxes are generate loops in the top level.

## Test plan
- **Single beat.** M=N=4. Input 2 sends Pld=0xA5A5, Dst=3, Last=1 -> oDcpOut[3] Vld the next cycle with Pld=0xA5A5, oLast=1; no other output valid.
- **Round-robin fairness.** Inputs 0..3 all stream single-beat packets to Dst=1 with Rdy=1 -> grants 0,1,2,3,0 on consecutive cycles. With ARB_MODE=1 -> input 0 wins every cycle.
- **Packet lock.** Input 1 sends 3 beats (Last=0,0,1) to Dst=0 while input 0 requests Dst=0 -> three input-1 beats back-to-back, then input 0.
- **Backpressure.** oDcpOut[2].Rdy=0 for 5 cycles -> Vld and Pld stable throughout. iDcpIn.Rdy drops after DEPTH beats are accepted. No loss after Rdy returns.
- **Drop saturation.** N=4, CNT_W=8. Input 3 sends 300 beats with Dst=7 -> no output Vld; oDropCnt[3] reads 255.
- **Mid-packet reset.** Assert iRst_n=0 mid-packet while LOCKED -> all Vld/Rdy=0. After release, a new packet from a different input is granted immediately.
